// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory and latches the word into IR.
// Optional macro FETCH_HALT_DETECT_EN adds a HALT state entered on opcode 6'b111111.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned FETCH_LAT = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic        PCWrite,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jr_addr,
    input  logic [31:0] Ins,
    output logic [31:0] pc,
    output logic        InsMemRW,
    output logic [31:0] IR,
    output logic        ir_valid,
    output logic [31:0] pc_plus4,
    output logic        fetch_busy,
    output logic        addr_fault,
    output logic        halted
);

    localparam logic [2:0] LatLast = 3'(FETCH_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StCap
`ifdef FETCH_HALT_DETECT_EN
        , StHalt
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        fault_q, fault_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic [31:0] npc;
    logic [31:0] pc_eff;
    logic        legal;

    assign pc_plus4 = pc_q + 32'd4;

    // Jump target uses the IR currently held, never the word in flight.
    always_comb begin
        npc = pc_plus4;
        unique case (PCSrc)
            2'b00: npc = pc_plus4;
            2'b01: npc = pc_plus4 + (imm_ext << 2);
            2'b10: npc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            2'b11: npc = jr_addr;
        endcase
    end

    // A fetch requested together with PCWrite uses the new pc for both check and read.
    assign pc_eff = PCWrite ? npc : pc_q;
    assign legal  = (pc_eff[1:0] == 2'b00) && (({1'b0, pc_eff} + 33'd3) < 33'(MEM_BYTES));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        fault_d      = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        unique case (state_q)
            StIdle: begin
                if (PCWrite) begin
                    pc_d = npc;
                end
                if (fetch_req) begin
                    if (legal) begin
                        state_d = StRead;
                        cnt_d   = 3'd0;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (PCWrite) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = npc;
                end
                if (cnt_q == LatLast) begin
                    state_d = StCap;
                    ir_d    = Ins;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StCap: begin
                // pc is held through the read; the latest requested update lands here.
                if (PCWrite) begin
                    pc_d = npc;
                end else if (pend_valid_q) begin
                    pc_d = pend_pc_q;
                end
                pend_valid_d = 1'b0;
                state_d      = StIdle;
`ifdef FETCH_HALT_DETECT_EN
                if (ir_q[31:26] == 6'b111111) begin
                    state_d = StHalt;
                end
`endif
            end
`ifdef FETCH_HALT_DETECT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            pc_q         <= RESET_PC;
            ir_q         <= 32'd0;
            fault_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            fault_q      <= fault_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pc         = pc_q;
    assign IR         = ir_q;
    assign addr_fault = fault_q;
    assign InsMemRW   = (state_q == StRead);
    assign ir_valid   = (state_q == StCap);
    assign fetch_busy = (state_q == StRead) || (state_q == StCap);
`ifdef FETCH_HALT_DETECT_EN
    assign halted     = (state_q == StHalt);
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance with FETCH_LAT=1, one with FETCH_LAT=3.
module tb_fetch_unit;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset, fetch_req, PCWrite;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext, jr_addr, Ins;
    logic [31:0] pc, IR, pc_plus4;
    logic        InsMemRW, ir_valid, fetch_busy, addr_fault, halted;

    logic        Reset3, fetch_req3, PCWrite3;
    logic [31:0] Ins3, pc3, IR3, pc_plus4_3;
    logic        InsMemRW3, ir_valid3, fetch_busy3, addr_fault3, halted3;

    logic [7:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(128), .FETCH_LAT(1)) dut (
        .CLK(CLK), .Reset(Reset), .fetch_req(fetch_req), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .imm_ext(imm_ext), .jr_addr(jr_addr), .Ins(Ins), .pc(pc), .InsMemRW(InsMemRW),
        .IR(IR), .ir_valid(ir_valid), .pc_plus4(pc_plus4), .fetch_busy(fetch_busy),
        .addr_fault(addr_fault), .halted(halted)
    );

    fetch_unit #(.RESET_PC(32'h8), .MEM_BYTES(128), .FETCH_LAT(3)) dut3 (
        .CLK(CLK), .Reset(Reset3), .fetch_req(fetch_req3), .PCWrite(PCWrite3), .PCSrc(PCSrc),
        .imm_ext(imm_ext), .jr_addr(jr_addr), .Ins(Ins3), .pc(pc3), .InsMemRW(InsMemRW3),
        .IR(IR3), .ir_valid(ir_valid3), .pc_plus4(pc_plus4_3), .fetch_busy(fetch_busy3),
        .addr_fault(addr_fault3), .halted(halted3)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a <= 32'd124) return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
        return 32'd0;
    endfunction

    // Memory returns the word at the pc visible after each edge.
    task automatic step();
        @(posedge CLK);
        #1;
        Ins  = rd(pc);
        Ins3 = rd(pc3);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        mem[0] = 8'h02; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h08;
        mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
        mem[64] = 8'hFC; mem[65] = 8'h00; mem[66] = 8'h00; mem[67] = 8'h00;

        Reset = 1; Reset3 = 1; fetch_req = 0; PCWrite = 0; PCSrc = 2'b00;
        imm_ext = 0; jr_addr = 0; fetch_req3 = 0; PCWrite3 = 0; Ins = 0; Ins3 = 0;
        step(); step();
        Reset = 0; Reset3 = 0;

        // Reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", IR, 32'h0);
        chk("rst_irv", ir_valid, 0);
        chk("rst_rw", InsMemRW, 0);
        chk("rst_fault", addr_fault, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_pc3", pc3, 32'h8);
        chk("pc_plus4", pc_plus4, 32'h4);

        // Basic fetch at pc=0
        fetch_req = 1; step(); fetch_req = 0;
        chk("f1_rw", InsMemRW, 1);
        chk("f1_irv0", ir_valid, 0);
        chk("f1_busy", fetch_busy, 1);
        step();
        chk("f1_irv", ir_valid, 1);
        chk("f1_ir", IR, 32'h0200_0008);
        chk("f1_rw_cap", InsMemRW, 0);
        step();
        chk("f1_irv_end", ir_valid, 0);
        chk("f1_busy_end", fetch_busy, 0);

        // PCWrite in IDLE, then PCWrite+fetch_req together
        PCWrite = 1; PCSrc = 2'b00; step(); PCWrite = 0;
        chk("pcw_pc4", pc, 32'h4);
        fetch_req = 1; PCWrite = 1; step(); fetch_req = 0; PCWrite = 0;
        chk("f2_pc", pc, 32'h8);
        chk("f2_rw", InsMemRW, 1);
        step();
        chk("f2_ir", IR, 32'h1122_3344);
        step();

        // Branch -1 during READ at pc=16
        PCWrite = 1; PCSrc = 2'b11; jr_addr = 32'h10; step(); PCWrite = 0;
        chk("jr_pc16", pc, 32'h10);
        fetch_req = 1; step(); fetch_req = 0;
        PCWrite = 1; PCSrc = 2'b01; imm_ext = 32'hFFFF_FFFF; step(); PCWrite = 0;
        chk("b_m1_cap", pc, 32'h10);
        step();
        chk("b_m1_idle", pc, 32'h10);

        // Pending branch held until CAP exit
        fetch_req = 1; step(); fetch_req = 0;
        PCWrite = 1; PCSrc = 2'b01; imm_ext = 32'h3; step(); PCWrite = 0;
        chk("pend_hold", pc, 32'h10);
        chk("pend_ir", IR, 32'h1011_1213);
        step();
        chk("pend_apply", pc, 32'h20);

        // Second PCWrite overrides pending entry
        fetch_req = 1; step(); fetch_req = 0;
        PCWrite = 1; PCSrc = 2'b01; imm_ext = 32'h3; step();
        PCSrc = 2'b11; jr_addr = 32'h24;
        chk("lw_hold", pc, 32'h20);
        chk("lw_ir", IR, 32'h2021_2223);
        step(); PCWrite = 0;
        chk("lw_pc", pc, 32'h24);

        // Jump uses held IR
        PCWrite = 1; PCSrc = 2'b10; step(); PCWrite = 0;
        chk("jump_pc", pc, 32'h0084_888C);

        // Bounds faults, checked against the new pc
        PCWrite = 1; PCSrc = 2'b11; jr_addr = 32'd126; fetch_req = 1; step();
        PCWrite = 0; fetch_req = 0;
        chk("f126_pc", pc, 32'd126);
        chk("f126_fault", addr_fault, 1);
        chk("f126_rw", InsMemRW, 0);
        step();
        chk("f126_fault_end", addr_fault, 0);
        chk("f126_ir", IR, 32'h2021_2223);
        chk("f126_rw2", InsMemRW, 0);
        PCWrite = 1; jr_addr = 32'd2; fetch_req = 1; step(); PCWrite = 0; fetch_req = 0;
        chk("f2_fault", addr_fault, 1);
        chk("f2_busy", fetch_busy, 0);
        step();
        chk("f2_fault_end", addr_fault, 0);
        PCWrite = 1; jr_addr = 32'd128; fetch_req = 1; step(); PCWrite = 0; fetch_req = 0;
        chk("f128_fault", addr_fault, 1);
        step();
        PCWrite = 1; jr_addr = 32'd124; fetch_req = 1; step(); PCWrite = 0; fetch_req = 0;
        chk("f124_fault", addr_fault, 0);
        chk("f124_rw", InsMemRW, 1);
        step();
        chk("f124_ir", IR, 32'h7C7D_7E7F);
        step();

        // Opcode 111111
        PCWrite = 1; jr_addr = 32'h40; fetch_req = 1; step(); PCWrite = 0; fetch_req = 0;
        chk("op3f_rw", InsMemRW, 1);
        step();
        chk("op3f_ir", IR, 32'hFC00_0000);
        chk("op3f_irv", ir_valid, 1);
        step();
        chk("op3f_irv_end", ir_valid, 0);
`ifdef FETCH_HALT_DETECT_EN
        chk("halt_set", halted, 1);
        fetch_req = 1; PCWrite = 1; PCSrc = 2'b11; jr_addr = 32'h0; step();
        fetch_req = 0; PCWrite = 0;
        chk("halt_rw", InsMemRW, 0);
        chk("halt_pc", pc, 32'h40);
        chk("halt_hold", halted, 1);
        step();
        chk("halt_irv", ir_valid, 0);
        Reset = 1; step(); Reset = 0;
        chk("halt_rst", halted, 0);
        chk("halt_rst_pc", pc, 32'h0);
`else
        chk("nohalt", halted, 0);
        fetch_req = 1; step(); fetch_req = 0;
        chk("nohalt_rw", InsMemRW, 1);
        step();
        chk("nohalt_irv", ir_valid, 1);
        step();
`endif

        // FETCH_LAT=3 latency
        fetch_req3 = 1; step(); fetch_req3 = 0;
        chk("l3_rw0", InsMemRW3, 1);
        step();
        chk("l3_rw1", InsMemRW3, 1);
        step();
        chk("l3_rw2", InsMemRW3, 1);
        chk("l3_irv_early", ir_valid3, 0);
        step();
        chk("l3_irv", ir_valid3, 1);
        chk("l3_ir", IR3, 32'h1122_3344);
        chk("l3_rw_cap", InsMemRW3, 0);
        step();
        chk("l3_irv_end", ir_valid3, 0);

        // Reset aborts a read in progress
        PCWrite3 = 1; PCSrc = 2'b11; jr_addr = 32'h0; step(); PCWrite3 = 0;
        chk("l3_pc0", pc3, 32'h0);
        fetch_req3 = 1; step(); fetch_req3 = 0;
        chk("l3_rd", InsMemRW3, 1);
        step();
        Reset3 = 1; step(); Reset3 = 0;
        chk("abort_pc", pc3, 32'h8);
        chk("abort_rw", InsMemRW3, 0);
        chk("abort_busy", fetch_busy3, 0);
        chk("abort_ir", IR3, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_irv", ir_valid3, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly upstream of the byte-addressed, big-endian instruction memory in the multicycle CPU.
- Owns the PC register and drives `pc` and `InsMemRW` into the memory.
- Captures the returned 32-bit `Ins` into the instruction register (IR) and handshakes with the control unit through `fetch_req`/`ir_valid`.
- Computes next-PC from four sources on `PCWrite`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 128, instruction memory size in bytes; used for the bounds check.
- FETCH_LAT, 1, cycles `InsMemRW` is held high before `Ins` is sampled into IR (1..7).

Ports:
- CLK  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- fetch_req  in  1  control unit requests an instruction fetch at the current pc
- PCWrite  in  1  update pc from the PCSrc selection
- PCSrc  in  2  00 pc+4; 01 pc+4+(imm_ext<<2); 10 {pc_plus4[31:28],IR[25:0],2'b00}; 11 jr_addr
- imm_ext  in  32  sign-extended branch offset
- jr_addr  in  32  register target for jr
- Ins  in  32  instruction word from the instruction memory
- pc  out  32  current PC, drives the memory address
- InsMemRW  out  1  memory read enable
- IR  out  32  latched instruction
- ir_valid  out  1  one-cycle pulse: IR updated this cycle
- pc_plus4  out  32  pc+4, combinational
- fetch_busy  out  1  high in READ and CAP
- addr_fault  out  1  one-cycle pulse: fetch rejected
- halted  out  1  halt status (see Optional Feature)

Behaviour:
- Reset values (synchronous, over any state): pc=RESET_PC, IR=0, ir_valid=0, InsMemRW=0, addr_fault=0, halted=0, FSM=IDLE, pending-PC cleared, latency counter=0.
- FSM states: IDLE, READ, CAP (plus HALT under the macro).
- IDLE:
  - fetch_req=1 with pc legal → READ; InsMemRW=1 from the next cycle; counter=0.
  - Legal means pc[1:0]==0 and pc+3 < MEM_BYTES.
  - fetch_req=1 with pc illegal → stay IDLE; addr_fault=1 for one cycle; IR unchanged; no read issued.
- READ:
  - InsMemRW=1.
  - Counter increments each cycle; at counter==FETCH_LAT-1 → CAP.
- CAP:
  - IR<=Ins; ir_valid=1 for exactly this cycle; InsMemRW=0; → IDLE.
  - Latency from fetch_req to ir_valid = FETCH_LAT+1 cycles.
- fetch_req is ignored outside IDLE; it is not queued.
- PCWrite in IDLE: pc updated at the same edge. New pc = selected source, 32-bit wrap-around, no overflow flag.
- PCWrite in READ/CAP:
  - Next-pc value computed with the current pc/IR/imm_ext/jr_addr and stored in a one-entry pending register.
  - Applied on the edge leaving CAP, so pc stays stable for the whole memory read.
  - A second PCWrite while an entry is pending overwrites it (last wins).
- PCWrite and fetch_req in the same IDLE cycle:
  - pc updates.
  - The fetch uses the new pc (READ starts next cycle), and the bounds check uses the new pc.
- PCSrc=10 uses the IR currently held, not the instruction in flight.
- Reset during READ/CAP aborts the read; no ir_valid is generated.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - In CAP, if Ins[31:26]==6'b111111, IR is still loaded and ir_valid still pulses.
  - FSM then enters HALT: halted=1; fetch_req and PCWrite ignored; InsMemRW=0.
  - Exit only by Reset.
- Undefined: no HALT state; opcode 111111 is treated like any other; halted tied 0.

Test Plan:
- Reset then fetch_req at pc=0, FETCH_LAT=1, memory bytes 0..3 = 8'h02,8'h00,8'h00,8'h08 → InsMemRW high 1 cycle, ir_valid 2 cycles after request, IR=32'h0200_0008.
- Fetch_req plus PCWrite with PCSrc=00 in IDLE at pc=4 → pc=8 and the fetch reads bytes 8..11.
- PCWrite PCSrc=01, imm_ext=32'hFFFF_FFFF issued during READ at pc=16 → pc holds 16 until CAP, then becomes 16 (20-4).
- fetch_req at pc=126 (MEM_BYTES=128), then at pc=2 → addr_fault pulses each time, no InsMemRW, IR unchanged.
- Reset asserted in READ, FETCH_LAT=3 → next cycle pc=RESET_PC, InsMemRW=0, no ir_valid.
- FETCH_HALT_DETECT_EN defined, Ins=32'hFC00_0000 → ir_valid once, halted=1, later fetch_req ignored until Reset.
